// File: rtl/ras_pkg.sv
// Shared decode constants, operation encoding and link-register helper for the
// return-address-stack controller.
package ras_pkg;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [4:0] REG_X1 = 5'd1;
  localparam logic [4:0] REG_X5 = 5'd5;

  // 16-bit encodings: quadrant in [1:0], funct3 in [15:13], funct4 in [15:12]
  localparam logic [1:0] RVC_Q1      = 2'b01;
  localparam logic [1:0] RVC_Q2      = 2'b10;
  localparam logic [1:0] RVC_Q_NONE  = 2'b11;
  localparam logic [2:0] RVC_F3_JAL  = 3'b001;
  localparam logic [3:0] RVC_F4_JR   = 4'b1000;
  localparam logic [3:0] RVC_F4_JALR = 4'b1001;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_X1) || (r == REG_X5);
  endfunction

endpackage

// File: rtl/ras_decode.sv
// Combinational classifier: instruction word -> stack operation, zero latency.
// RAS_RVC_EN adds 16-bit c.jal / c.jalr / c.jr decoding; otherwise those are NONE.
module ras_decode
  import ras_pkg::*;
(
  input  logic [31:0] instr_i,
  output ras_op_e     op_o,
  output logic        is_c_o
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       imm_unused;

  assign opcode     = instr_i[6:0];
  assign rd         = instr_i[11:7];
  assign rs1        = instr_i[19:15];
  assign imm_unused = ^{instr_i[31:20], instr_i[14:12]};

`ifdef RAS_RVC_EN
  logic [4:0] c_rs1;
  logic [4:0] c_rs2;
  assign c_rs1 = instr_i[11:7];
  assign c_rs2 = instr_i[6:2];
`endif

  always_comb begin
    op_o   = RAS_NONE;
    is_c_o = 1'b0;
    if (instr_i[1:0] == RVC_Q_NONE) begin
      if (opcode == OP_JAL) begin
        if (is_link(rd)) op_o = RAS_PUSH;
      end else if (opcode == OP_JALR) begin
        // x1/x5 used as both rd and rs1 but different: return then call (coroutine swap)
        unique case ({is_link(rd), is_link(rs1)})
          2'b01:   op_o = RAS_POP;
          2'b10:   op_o = RAS_PUSH;
          2'b11:   op_o = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
          default: op_o = RAS_NONE;
        endcase
      end
    end
`ifdef RAS_RVC_EN
    else begin
      is_c_o = 1'b1;
      if (instr_i[1:0] == RVC_Q1 && instr_i[15:13] == RVC_F3_JAL) begin
        op_o = RAS_PUSH;
      end else if (instr_i[1:0] == RVC_Q2 && c_rs2 == 5'd0 && c_rs1 != 5'd0) begin
        if (instr_i[15:12] == RVC_F4_JALR) begin
          op_o = (c_rs1 == REG_X5) ? RAS_POPPUSH : RAS_PUSH;
        end else if (instr_i[15:12] == RVC_F4_JR && is_link(c_rs1)) begin
          op_o = RAS_POP;
        end
      end
    end
`endif
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address stack: same-cycle prediction from fetch, speculative and committed
// pointers, flush restores speculative pointers from committed ones. Macro: RAS_RVC_EN.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic [31:0]      fetch_instr,
  input  logic             commit_valid,
  input  logic [31:0]      commit_instr,
  input  logic             flush,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_target,
  output logic             ras_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    ptr_t ptr;
    cnt_t cnt;
  } ras_st_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  // Pointer/count arithmetic shared by the speculative and committed copies
  function automatic ras_st_t ras_step(input ras_op_e op, input ras_st_t s);
    ras_st_t n;
    n = s;
    unique case (op)
      RAS_PUSH: begin
        n.ptr = s.ptr + ptr_t'(1);
        n.cnt = (s.cnt == CNT_FULL) ? s.cnt : s.cnt + cnt_t'(1);
      end
      RAS_POP: begin
        if (s.cnt != '0) begin
          n.ptr = s.ptr - ptr_t'(1);
          n.cnt = s.cnt - cnt_t'(1);
        end
      end
      RAS_POPPUSH: begin
        if (s.cnt == '0) begin
          n.ptr = s.ptr + ptr_t'(1);
          n.cnt = cnt_t'(1);
        end
      end
      default: n = s;
    endcase
    return n;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  ras_st_t          spec_q, spec_d;
  ras_st_t          com_q, com_d;

  ras_op_e          fetch_op;
  logic             fetch_is_c;
  ras_op_e          commit_op;
  logic             commit_is_c_unused;

  ptr_t             top_idx;
  logic             spec_nonempty;
  logic [WIDTH-1:0] push_data;
  logic             mem_we;
  ptr_t             mem_widx;

  ras_decode u_fetch_dec (
    .instr_i (fetch_instr),
    .op_o    (fetch_op),
    .is_c_o  (fetch_is_c)
  );

  ras_decode u_commit_dec (
    .instr_i (commit_instr),
    .op_o    (commit_op),
    .is_c_o  (commit_is_c_unused)
  );

  assign top_idx       = spec_q.ptr - ptr_t'(1);
  assign spec_nonempty = (spec_q.cnt != '0);
  assign push_data     = fetch_pc + (fetch_is_c ? WIDTH'(2) : WIDTH'(4));

  assign pred_valid  = fetch_valid && spec_nonempty &&
                       (fetch_op == RAS_POP || fetch_op == RAS_POPPUSH);
  assign pred_target = pred_valid ? mem_q[top_idx] : '0;
  assign ras_empty   = !spec_nonempty;

  // POPPUSH replaces the current top; on an empty stack it degenerates to a push
  assign mem_we   = fetch_valid && !flush &&
                    (fetch_op == RAS_PUSH || fetch_op == RAS_POPPUSH);
  assign mem_widx = (fetch_op == RAS_POPPUSH && spec_nonempty) ? top_idx : spec_q.ptr;

  always_comb begin
    com_d  = commit_valid ? ras_step(commit_op, com_q) : com_q;
    spec_d = spec_q;
    if (flush) begin
      spec_d = com_d;
    end else if (fetch_valid) begin
      spec_d = ras_step(fetch_op, spec_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_q <= '0;
      com_q  <= '0;
    end else begin
      spec_q <= spec_d;
      com_q  <= com_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_widx] <= push_data;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed vector bench for ras_ctrl; expectations are hand-computed return addresses.
module tb_ras_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

`ifdef RAS_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  localparam logic [31:0] I_JAL_X1   = 32'h0000_00EF;
  localparam logic [31:0] I_JAL_X5   = 32'h0000_02EF;
  localparam logic [31:0] I_RET      = 32'h0000_8067;  // jalr x0,0(x1)
  localparam logic [31:0] I_CALL_R   = 32'h0005_00E7;  // jalr x1,0(x10)
  localparam logic [31:0] I_JALR_11  = 32'h0000_80E7;  // jalr x1,0(x1)
  localparam logic [31:0] I_SWAP     = 32'h0002_80E7;  // jalr x1,0(x5)
  localparam logic [31:0] I_JMP_R    = 32'h0005_0067;  // jalr x0,0(x10)
  localparam logic [31:0] I_NOP      = 32'h0000_0013;
  localparam logic [31:0] I_C_JAL    = 32'h0000_2001;
  localparam logic [31:0] I_C_JR_X1  = 32'h0000_8082;
  localparam logic [31:0] I_C_JALR_5 = 32'h0000_9282;

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_valid;
  logic [WIDTH-1:0] fetch_pc;
  logic [31:0]      fetch_instr;
  logic             commit_valid;
  logic [31:0]      commit_instr;
  logic             flush;
  logic             pred_valid;
  logic [WIDTH-1:0] pred_target;
  logic             ras_empty;

  ras_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_instr  (fetch_instr),
    .commit_valid (commit_valid),
    .commit_instr (commit_instr),
    .flush        (flush),
    .pred_valid   (pred_valid),
    .pred_target  (pred_target),
    .ras_empty    (ras_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        cv;
    logic [31:0] cinstr;
    logic        fl;
    logic        epv;
    logic [31:0] ept;
    logic        eempty;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   row    = 0;

  function automatic void add(input logic r, input logic fv, input logic [31:0] pc,
                              input logic [31:0] instr, input logic cv,
                              input logic [31:0] cinstr, input logic fl,
                              input logic epv, input logic [31:0] ept, input logic eempty);
    vec_t v;
    v.rst = r; v.fv = fv; v.pc = pc; v.instr = instr; v.cv = cv; v.cinstr = cinstr;
    v.fl = fl; v.epv = epv; v.ept = ept; v.eempty = eempty;
    vecs.push_back(v);
  endfunction

  function automatic void addf(input logic [31:0] pc, input logic [31:0] instr,
                               input logic epv, input logic [31:0] ept, input logic eempty);
    add(1'b0, 1'b1, pc, instr, 1'b0, I_NOP, 1'b0, epv, ept, eempty);
  endfunction

  function automatic void addi(input logic eempty);
    add(1'b0, 1'b0, 32'h0, I_NOP, 1'b0, I_NOP, 1'b0, 1'b0, 32'h0, eempty);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h, want %h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst          = v.rst;
    fetch_valid  = v.fv;
    fetch_pc     = v.pc;
    fetch_instr  = v.instr;
    commit_valid = v.cv;
    commit_instr = v.cinstr;
    flush        = v.fl;
    #1;
    check("pred_valid", {31'b0, pred_valid}, {31'b0, v.epv});
    check("pred_target", pred_target, v.ept);
    check("ras_empty", {31'b0, ras_empty}, {31'b0, v.eempty});
    row++;
  endtask

  task automatic run_f(input logic [31:0] pc, input logic [31:0] instr,
                       input logic epv, input logic [31:0] ept, input logic eempty);
    vec_t v;
    v.rst = 1'b0; v.fv = 1'b1; v.pc = pc; v.instr = instr; v.cv = 1'b0; v.cinstr = I_NOP;
    v.fl = 1'b0; v.epv = epv; v.ept = ept; v.eempty = eempty;
    apply(v);
  endtask

  initial begin
    vec_t v;

    // Reset overrides same-cycle fetch/commit; pop on empty stays empty
    add(1'b1, 1'b1, 32'h500, I_JAL_X1, 1'b1, I_JAL_X1, 1'b0, 1'b0, 32'h0, 1'b1);
    addf(32'h504, I_RET, 1'b0, 32'h0, 1'b1);
    // Single call/return
    addf(32'h100, I_JAL_X1, 1'b0, 32'h0, 1'b1);
    addi(1'b0);
    addf(32'h104, I_RET, 1'b1, 32'h104, 1'b0);
    addi(1'b1);
    // Nested calls, non-fetch and non-control rows, then returns
    addf(32'h10, I_JAL_X1, 1'b0, 32'h0, 1'b1);
    addf(32'h20, I_JAL_X5, 1'b0, 32'h0, 1'b0);
    addf(32'h30, I_CALL_R, 1'b0, 32'h0, 1'b0);
    add(1'b0, 1'b0, 32'h34, I_RET, 1'b0, I_NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    addf(32'h34, I_JMP_R, 1'b0, 32'h0, 1'b0);
    addf(32'h40, I_JALR_11, 1'b0, 32'h0, 1'b0);
    addf(32'h50, I_RET, 1'b1, 32'h44, 1'b0);
    addf(32'h60, I_RET, 1'b1, 32'h34, 1'b0);
    addf(32'h70, I_RET, 1'b1, 32'h24, 1'b0);
    addf(32'h80, I_RET, 1'b1, 32'h14, 1'b0);
    addi(1'b1);
    // POPPUSH on a non-empty and on an empty stack
    addf(32'h4C, I_JAL_X1, 1'b0, 32'h0, 1'b1);
    addf(32'h200, I_SWAP, 1'b1, 32'h50, 1'b0);
    addi(1'b0);
    addf(32'h208, I_RET, 1'b1, 32'h204, 1'b0);
    addi(1'b1);
    addf(32'h210, I_SWAP, 1'b0, 32'h0, 1'b1);
    addi(1'b0);
    addf(32'h218, I_RET, 1'b1, 32'h214, 1'b0);
    addi(1'b1);
    // Flush: two committed pushes survive, three speculative ones and a same-cycle push do not
    add(1'b0, 1'b0, 32'h0, I_NOP, 1'b0, I_NOP, 1'b1, 1'b0, 32'h0, 1'b1);
    add(1'b0, 1'b1, 32'h600, I_JAL_X1, 1'b1, I_JAL_X1, 1'b0, 1'b0, 32'h0, 1'b1);
    add(1'b0, 1'b1, 32'h610, I_JAL_X1, 1'b1, I_JAL_X1, 1'b0, 1'b0, 32'h0, 1'b0);
    addf(32'h620, I_JAL_X1, 1'b0, 32'h0, 1'b0);
    addf(32'h630, I_JAL_X1, 1'b0, 32'h0, 1'b0);
    addf(32'h640, I_JAL_X1, 1'b0, 32'h0, 1'b0);
    add(1'b0, 1'b1, 32'h700, I_JAL_X1, 1'b0, I_NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    addf(32'h710, I_RET, 1'b1, 32'h614, 1'b0);
    addf(32'h720, I_RET, 1'b1, 32'h604, 1'b0);
    addf(32'h730, I_RET, 1'b0, 32'h0, 1'b1);
    // Flush picks up the same-cycle committed return (committed depth 2 -> 1)
    add(1'b0, 1'b0, 32'h0, I_NOP, 1'b1, I_RET, 1'b1, 1'b0, 32'h0, 1'b1);
    addf(32'h740, I_RET, 1'b1, 32'h604, 1'b0);
    addi(1'b1);
    // Compressed call/return pairs
    addf(32'h300, I_C_JAL, 1'b0, 32'h0, 1'b1);
    addf(32'h302, I_C_JR_X1, RVC, RVC ? 32'h302 : 32'h0, !RVC);
    addi(1'b1);
    addf(32'h400, I_C_JALR_5, 1'b0, 32'h0, 1'b1);
    addf(32'h404, I_RET, RVC, RVC ? 32'h402 : 32'h0, !RVC);
    addi(1'b1);

    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = I_NOP;
    commit_valid = 1'b0; commit_instr = I_NOP; flush = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    // DEPTH+1 pushes: oldest entry overwritten, then DEPTH pops, then one on empty
    for (int k = 0; k <= DEPTH; k++) begin
      run_f(32'h1000 + 32'(4 * k), I_JAL_X1, 1'b0, 32'h0, k == 0);
    end
    for (int j = 0; j < DEPTH; j++) begin
      run_f(32'h2000, I_RET, 1'b1, 32'h1044 - 32'(4 * j), 1'b0);
    end
    run_f(32'h2000, I_RET, 1'b0, 32'h0, 1'b1);
    run_f(32'h2004, I_NOP, 1'b0, 32'h0, 1'b1);

    // Mid-run reset beats flush, fetch and commit, and clears the committed copy too
    v.rst = 1'b0; v.fv = 1'b1; v.pc = 32'h800; v.instr = I_JAL_X1; v.cv = 1'b1;
    v.cinstr = I_JAL_X1; v.fl = 1'b0; v.epv = 1'b0; v.ept = 32'h0; v.eempty = 1'b1;
    apply(v);
    v.rst = 1'b1; v.fl = 1'b1; v.pc = 32'h810; v.eempty = 1'b0;
    apply(v);
    run_f(32'h820, I_RET, 1'b0, 32'h0, 1'b1);
    v.rst = 1'b0; v.fv = 1'b0; v.cv = 1'b0; v.fl = 1'b1; v.eempty = 1'b1;
    apply(v);
    run_f(32'h830, I_RET, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
